mem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 28 ++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the I/D-cache memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    localparam int unsigned MEM_LATENCY_DEF = 10;
    localparam int unsigned LINE_BITS_DEF   = 128;
    localparam int unsigned ADDR_W_DEF      = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant logic; ARB_DCACHE_PRIO_EN makes the D-cache win every tie.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic req_icache_i,
    input  logic req_dcache_i,
    input  logic last_grant_i,
    output logic grant_dcache_c,
    output logic any_req_c
);

    assign any_req_c = req_icache_i | req_dcache_i;

`ifdef ARB_DCACHE_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
    assign grant_dcache_c    = req_dcache_i;
`else
    // On a tie the requester not served last wins.
    always_comb begin
        grant_dcache_c = req_dcache_i;
        if (req_icache_i && req_dcache_i) begin
            grant_dcache_c = (last_grant_i == logic'(GRANT_I));
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the line-wide memory port between I-cache and D-cache with round-robin grant.
// Optional ARB_DCACHE_PRIO_EN: D-cache strictly wins ties (handled in rr_arbiter2).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LINE_BITS   = LINE_BITS_DEF,
    parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_icache_read_en,
    input  logic [ADDR_W-1:0]    in_icache_addr,
    output logic [LINE_BITS-1:0] out_icache_read_data,
    output logic                 out_icache_ready,
    input  logic                 in_dcache_read_en,
    input  logic                 in_dcache_write_en,
    input  logic [ADDR_W-1:0]    in_dcache_addr,
    input  logic [LINE_BITS-1:0] in_dcache_write_data,
    output logic [LINE_BITS-1:0] out_dcache_read_data,
    output logic                 out_dcache_ready,
    output logic                 out_mem_read_en,
    output logic                 out_mem_write_en,
    output logic [ADDR_W-1:0]    out_mem_addr,
    output logic [LINE_BITS-1:0] out_mem_write_data,
    input  logic [LINE_BITS-1:0] in_mem_read_data
);

    localparam int unsigned OFF_W    = $clog2(LINE_BITS / 8);
    localparam int unsigned CNT_W    = $clog2(MEM_LATENCY);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

    state_e                state_q, state_d;
    grant_e                gnt_q, gnt_d;
    grant_e                last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [LINE_BITS-1:0]  wdata_q, wdata_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0]  mem_wdata_q, mem_wdata_d;
    logic                  irdy_q, irdy_d;
    logic                  drdy_q, drdy_d;
    logic [LINE_BITS-1:0]  irdata_q, irdata_d;
    logic [LINE_BITS-1:0]  drdata_q, drdata_d;

    logic dreq_c;
    logic grant_dcache_c;
    logic any_req_c;

    assign dreq_c = in_dcache_read_en | in_dcache_write_en;

    rr_arbiter2 u_arb (
        .req_icache_i   (in_icache_read_en),
        .req_dcache_i   (dreq_c),
        .last_grant_i   (logic'(last_q)),
        .grant_dcache_c (grant_dcache_c),
        .any_req_c      (any_req_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= GRANT_I;
            last_q      <= GRANT_I;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            irdy_q      <= 1'b0;
            drdy_q      <= 1'b0;
            irdata_q    <= '0;
            drdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            irdy_q      <= irdy_d;
            drdy_q      <= drdy_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        irdy_d      = 1'b0;
        drdy_d      = 1'b0;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;

        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    cnt_d   = '0;
                    state_d = ACCESS;
                    if (grant_dcache_c) begin
                        gnt_d   = GRANT_D;
                        wr_d    = in_dcache_write_en;
                        addr_d  = in_dcache_addr;
                        wdata_d = in_dcache_write_en ? in_dcache_write_data : '0;
                    end else begin
                        gnt_d   = GRANT_I;
                        wr_d    = 1'b0;
                        addr_d  = in_icache_addr;
                        wdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = RESP;
                    if (gnt_q == GRANT_D) begin
                        drdy_d = 1'b1;
                        if (!wr_q) drdata_d = in_mem_read_data;
                    end else begin
                        irdy_d   = 1'b1;
                        irdata_d = in_mem_read_data;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                cnt_d   = '0;
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Memory strobes are registered so they are valid for every ACCESS cycle.
        if (state_d == ACCESS) begin
            mem_rd_d    = !wr_d;
            mem_wr_d    = wr_d;
            mem_addr_d  = {addr_d[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata_d = wdata_d;
        end
    end

    assign out_icache_read_data = irdata_q;
    assign out_icache_ready     = irdy_q;
    assign out_dcache_read_data = drdata_q;
    assign out_dcache_ready     = drdy_q;
    assign out_mem_read_en      = mem_rd_q;
    assign out_mem_write_en     = mem_wr_q;
    assign out_mem_addr         = mem_addr_q;
    assign out_mem_write_data   = mem_wdata_q;

endmodule
